// File: rtl/mem_pkg.sv
// Shared encodings for the CPU memory request path: access sizes, error causes,
// FSM state codes and the byte-lane mask used by both initiator and controller.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_SIZE     = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef logic [2:0] mem_state_t;
  localparam mem_state_t ST_IDLE      = 3'd0;
  localparam mem_state_t ST_CHECK     = 3'd1;
  localparam mem_state_t ST_ISSUE     = 3'd2;
  localparam mem_state_t ST_WAIT_RESP = 3'd3;
  localparam mem_state_t ST_DONE      = 3'd4;
  localparam mem_state_t ST_ERROR     = 3'd5;

  // Built little-endian first (offset k -> bit k), then mirrored for big-endian.
  function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                             input logic [1:0] offset,
                                             input logic       big_endian);
    logic [3:0] le;
    case (size)
      SIZE_BYTE: le = 4'b0001 << offset;
      SIZE_HALF: le = offset[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: le = 4'b1111;
      default:   le = 4'b0000;
    endcase
    return big_endian ? {le[0], le[1], le[2], le[3]} : le;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module mem_load_align
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] i_read_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_result
);

  logic [1:0]  w_lane;
  logic        w_half_hi;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Big-endian offset k lives in lane 3-k, which is simply ~k for two bits.
  assign w_lane    = BIG_ENDIAN ? ~i_offset : i_offset;
  assign w_half_hi = BIG_ENDIAN ? ~i_offset[1] : i_offset[1];
  assign w_half    = w_half_hi ? i_read_word[31:16] : i_read_word[15:0];

  always_comb begin
    w_byte = i_read_word[7:0];
    case (w_lane)
      2'd0: w_byte = i_read_word[7:0];
      2'd1: w_byte = i_read_word[15:8];
      2'd2: w_byte = i_read_word[23:16];
      2'd3: w_byte = i_read_word[31:24];
      default: w_byte = i_read_word[7:0];
    endcase
  end

  always_comb begin
    o_result = i_read_word;
    case (i_size)
      SIZE_BYTE: o_result = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: o_result = {{16{~i_unsigned & w_half[15]}}, w_half};
      default:   o_result = i_read_word;
    endcase
  end

endmodule

// File: rtl/mem_request_master.sv
// CPU-side initiator: checks a load/store, issues one word-aligned bus request with
// byte enables, waits (bounded) for the response and returns extended load data.
module mem_request_master
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit BIG_ENDIAN     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req_valid,
  input  logic        cpu_is_store,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_store_data,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [31:0] cpu_load_data,
  output logic        cpu_error,
  output logic [1:0]  cpu_error_cause,
  output logic        mc_req_valid,
  input  logic        mc_req_ready,
  output logic        mc_wr_en,
  output logic [31:0] mc_address,
  output logic [31:0] mc_write_data,
  output logic [3:0]  mc_byte_en,
  input  logic        mc_resp_valid,
  input  logic [31:0] mc_read_data,
  output logic [2:0]  dbg_state
);

  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t  r_state;
  logic        r_is_store;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic [1:0]  r_cause;
  logic        r_mc_wr;
  logic [31:0] r_mc_addr;
  logic [31:0] r_mc_wdata;
  logic [3:0]  r_mc_be;

  logic        w_misalign;
  logic [31:0] w_wdata;
  logic [31:0] w_aligned;

  assign w_misalign = ((r_size == SIZE_HALF) && r_addr[0]) ||
                      ((r_size == SIZE_WORD) && (r_addr[1:0] != 2'b00));

  always_comb begin
    w_wdata = r_sdata;
    case (r_size)
      SIZE_BYTE: w_wdata = {4{r_sdata[7:0]}};
      SIZE_HALF: w_wdata = {2{r_sdata[15:0]}};
      default:   w_wdata = r_sdata;
    endcase
  end

  mem_load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .i_read_word (r_rdata),
    .i_offset    (r_addr[1:0]),
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .o_result    (w_aligned)
  );

  // Request handshake: mc_req_valid holds with stable fields until a cycle where
  // mc_req_ready is also high; that cycle is the transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_is_store <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'h0;
      r_sdata    <= 32'h0;
      r_cnt      <= 8'h0;
      r_rdata    <= 32'h0;
      r_cause    <= CAUSE_NONE;
      r_mc_wr    <= 1'b0;
      r_mc_addr  <= 32'h0;
      r_mc_wdata <= 32'h0;
      r_mc_be    <= 4'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req_valid) begin
            r_is_store <= cpu_is_store;
            r_size     <= cpu_size;
            r_unsigned <= cpu_unsigned;
            r_addr     <= cpu_address;
            r_sdata    <= cpu_store_data;
            r_state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_size == SIZE_ILLEGAL) begin
            r_cause <= CAUSE_SIZE;
            r_state <= ST_ERROR;
          end else if (w_misalign) begin
            r_cause <= CAUSE_MISALIGN;
            r_state <= ST_ERROR;
          end else begin
            r_mc_wr    <= r_is_store;
            r_mc_addr  <= {r_addr[31:2], 2'b00};
            r_mc_wdata <= w_wdata;
            r_mc_be    <= byte_enable(r_size, r_addr[1:0], 1'(BIG_ENDIAN));
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mc_req_ready) begin
            r_cnt   <= 8'h0;
            r_state <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          // A response in the final allowed cycle still completes the access.
          if (mc_resp_valid) begin
            r_rdata <= mc_read_data;
            r_state <= ST_DONE;
          end else if (r_cnt == LP_LAST_WAIT) begin
            r_cause <= CAUSE_TIMEOUT;
            r_state <= ST_ERROR;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        ST_ERROR: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_busy        = (r_state != ST_IDLE);
  assign cpu_done        = (r_state == ST_DONE);
  assign cpu_error       = (r_state == ST_ERROR);
  assign cpu_error_cause = r_cause;
  assign cpu_load_data   = (cpu_done && !r_is_store) ? w_aligned : 32'h0;
  assign mc_req_valid    = (r_state == ST_ISSUE);
  assign mc_wr_en        = r_mc_wr;
  assign mc_address      = r_mc_addr;
  assign mc_write_data   = r_mc_wdata;
  assign mc_byte_en      = r_mc_be;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_mem_request_master.sv
// Bench for mem_request_master: directed plan cases plus randomized accesses
// checked against an arithmetic model of lanes, enables and extension.
module tb_mem_request_master;

  logic        clock;
  logic        reset_n;
  logic        cpu_req_valid;
  logic        cpu_is_store;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_address;
  logic [31:0] cpu_store_data;
  logic        cpu_busy;
  logic        cpu_done;
  logic [31:0] cpu_load_data;
  logic        cpu_error;
  logic [1:0]  cpu_error_cause;
  logic        mc_req_valid;
  logic        mc_req_ready;
  logic        mc_wr_en;
  logic [31:0] mc_address;
  logic [31:0] mc_write_data;
  logic [3:0]  mc_byte_en;
  logic        mc_resp_valid;
  logic [31:0] mc_read_data;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  mem_request_master #(.TIMEOUT_CYCLES(4), .BIG_ENDIAN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req_valid(cpu_req_valid), .cpu_is_store(cpu_is_store), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_address(cpu_address), .cpu_store_data(cpu_store_data),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_load_data(cpu_load_data),
    .cpu_error(cpu_error), .cpu_error_cause(cpu_error_cause),
    .mc_req_valid(mc_req_valid), .mc_req_ready(mc_req_ready), .mc_wr_en(mc_wr_en),
    .mc_address(mc_address), .mc_write_data(mc_write_data), .mc_byte_en(mc_byte_en),
    .mc_resp_valid(mc_resp_valid), .mc_read_data(mc_read_data), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [109:0] all_outputs();
    return {cpu_busy, cpu_done, cpu_load_data, cpu_error, cpu_error_cause, mc_req_valid,
            mc_wr_en, mc_address, mc_write_data, mc_byte_en, dbg_state};
  endfunction

  // Reference model: big-endian byte k is bits [31-8k -: 8]
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    int nb;
    int v;
    nb = nbytes(sz);
    v  = ((1 << nb) - 1) << (4 - int'(off) - nb);
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'b00) return {4{sd[7:0]}};
    if (sz == 2'b01) return {2{sd[15:0]}};
    return sd;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [1:0] off, input logic [31:0] w);
    int nb;
    logic [31:0] v;
    logic [31:0] mask;
    nb   = nbytes(sz);
    v    = w >> (8 * (4 - int'(off) - nb));
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    v    = v & mask;
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Driver: starts at a negedge with the DUT idle, ends at a negedge with it idle.
  task automatic run_access(input string name, input logic st, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                            input int rdy_dly, input int resp_lat, input logic [31:0] rword);
    logic        e_err;
    logic [1:0]  e_cause;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_ld;
    e_err   = 1'b0;
    e_cause = 2'b00;
    if (sz == 2'b11) begin
      e_err = 1'b1; e_cause = 2'b10;
    end else if ((sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)) begin
      e_err = 1'b1; e_cause = 2'b01;
    end
    e_be = model_be(sz, addr[1:0]);
    e_wd = model_wdata(sz, sd);
    if (!e_err) exp_q.push_back(st ? 32'h0 : model_load(sz, uns, addr[1:0], rword));

    cpu_req_valid = 1'b1; cpu_is_store = st; cpu_size = sz; cpu_unsigned = uns;
    cpu_address = addr; cpu_store_data = sd;
    @(negedge clock);
    cpu_req_valid = 1'($urandom_range(0, 1));
    cpu_is_store = 1'($urandom); cpu_size = 2'($urandom); cpu_unsigned = 1'($urandom);
    cpu_address = $urandom; cpu_store_data = $urandom;
    n_tests++;
    if ({cpu_busy, mc_req_valid, cpu_done, cpu_error} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s check_phase: busy/req/done/err=%b want 1000", name,
               {cpu_busy, mc_req_valid, cpu_done, cpu_error});
    end
    @(negedge clock);
    if (e_err) begin
      n_tests++;
      if ({cpu_error, cpu_error_cause, mc_req_valid, cpu_done} !== {1'b1, e_cause, 2'b00}) begin
        n_fail++;
        $display("FAIL %s error_pulse: err/cause/req/done=%b want %b", name,
                 {cpu_error, cpu_error_cause, mc_req_valid, cpu_done}, {1'b1, e_cause, 2'b00});
      end
      cpu_req_valid = 1'($urandom_range(0, 1));
      @(negedge clock);
      cpu_req_valid = 1'b0;
      n_tests++;
      if ({cpu_busy, cpu_error, cpu_error_cause} !== {2'b00, e_cause}) begin
        n_fail++;
        $display("FAIL %s error_after: busy/err/cause=%b want %b", name,
                 {cpu_busy, cpu_error, cpu_error_cause}, {2'b00, e_cause});
      end
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      mc_req_ready = (i == rdy_dly);
      n_tests++;
      if ({mc_req_valid, mc_wr_en, mc_address, mc_byte_en, mc_write_data} !==
          {1'b1, st, addr[31:2], 2'b00, e_be, e_wd}) begin
        n_fail++;
        $display("FAIL %s request_fields cyc%0d: v=%b we=%b a=%h be=%b wd=%h want v=1 we=%b a=%h be=%b wd=%h",
                 name, i, mc_req_valid, mc_wr_en, mc_address, mc_byte_en, mc_write_data,
                 st, {addr[31:2], 2'b00}, e_be, e_wd);
      end
      @(negedge clock);
    end
    mc_req_ready = 1'b0;
    n_tests++;
    if ({mc_req_valid, cpu_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s req_drop: valid/busy=%b want 01", name, {mc_req_valid, cpu_busy});
    end
    for (int i = 0; i < resp_lat; i++) begin
      @(negedge clock);
      n_tests++;
      if ({cpu_done, cpu_error, cpu_busy} !== 3'b001) begin
        n_fail++;
        $display("FAIL %s wait_resp cyc%0d: done/err/busy=%b want 001", name, i,
                 {cpu_done, cpu_error, cpu_busy});
      end
    end
    mc_resp_valid = 1'b1;
    mc_read_data  = rword;
    @(negedge clock);
    mc_resp_valid = 1'b0;
    mc_read_data  = $urandom;
    cpu_req_valid = 1'($urandom_range(0, 1));
    e_ld = exp_q.pop_front();
    n_tests++;
    if ({cpu_done, cpu_error, cpu_load_data} !== {2'b10, e_ld}) begin
      n_fail++;
      $display("FAIL %s done: done=%b err=%b data=%h want done=1 err=0 data=%h", name,
               cpu_done, cpu_error, cpu_load_data, e_ld);
    end
    @(negedge clock);
    cpu_req_valid = 1'b0;
    n_tests++;
    if ({cpu_busy, cpu_done, cpu_load_data} !== 34'h0) begin
      n_fail++;
      $display("FAIL %s idle_after: busy=%b done=%b data=%h want 0", name,
               cpu_busy, cpu_done, cpu_load_data);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_req_valid = 1'b0; cpu_is_store = 1'b0; cpu_size = 2'b00; cpu_unsigned = 1'b0;
    cpu_address = 32'h0; cpu_store_data = 32'h0;
    mc_req_ready = 1'b0; mc_resp_valid = 1'b0; mc_read_data = 32'h0;
    #1;
    n_tests++;
    if (all_outputs() !== 110'h0) begin
      n_fail++;
      $display("FAIL reset_state: outputs=%h want 0", all_outputs());
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_directed();
    run_access("lw_0x10", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF);
    run_access("lb_0x13", 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 0, 0, 32'h1122_3380);
    run_access("lbu_0x13", 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 0, 0, 32'h1122_3380);
    run_access("lhu_0x12", 1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, 0, 0, 32'h1122_3380);
    run_access("sh_stall", 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0000_ABCD, 6, 1, 32'h5555_5555);
    run_access("lw_misalign", 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 0, 0, 32'h0);
    run_access("size_illegal", 1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0, 0, 0, 32'h0);
    run_access("resp_at_limit", 1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0, 0, 3, 32'h8001_7FFF);
  endtask

  task automatic test_timeout();
    cpu_req_valid = 1'b1; cpu_is_store = 1'b0; cpu_size = 2'b10; cpu_unsigned = 1'b0;
    cpu_address = 32'h0000_0040; cpu_store_data = 32'h0;
    @(negedge clock);
    cpu_req_valid = 1'b0;
    @(negedge clock);
    mc_req_ready = 1'b1;
    @(negedge clock);
    mc_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({cpu_busy, cpu_error, cpu_done} !== 3'b100) begin
        n_fail++;
        $display("FAIL timeout_wait cyc%0d: busy/err/done=%b want 100", i,
                 {cpu_busy, cpu_error, cpu_done});
      end
      @(negedge clock);
    end
    n_tests++;
    if ({cpu_error, cpu_error_cause, cpu_done} !== 4'b1110) begin
      n_fail++;
      $display("FAIL timeout_error: err/cause/done=%b want 1110",
               {cpu_error, cpu_error_cause, cpu_done});
    end
    @(negedge clock);
    mc_resp_valid = 1'b1;
    mc_read_data  = 32'h1234_5678;
    @(negedge clock);
    mc_resp_valid = 1'b0;
    n_tests++;
    if ({cpu_busy, cpu_done, cpu_error, cpu_error_cause} !== 5'b00011) begin
      n_fail++;
      $display("FAIL late_ack: busy/done/err/cause=%b want 00011",
               {cpu_busy, cpu_done, cpu_error, cpu_error_cause});
    end
  endtask

  task automatic test_reset_mid();
    cpu_req_valid = 1'b1; cpu_is_store = 1'b1; cpu_size = 2'b00; cpu_unsigned = 1'b0;
    cpu_address = 32'h0000_0081; cpu_store_data = 32'h0000_00A5;
    @(negedge clock);
    cpu_req_valid = 1'b0;
    @(negedge clock);
    mc_req_ready = 1'b1;
    @(negedge clock);
    mc_req_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (all_outputs() !== 110'h0) begin
      n_fail++;
      $display("FAIL async_reset: outputs=%h want 0", all_outputs());
    end
    @(negedge clock);
    reset_n = 1'b1;
    mc_resp_valid = 1'b1;
    @(negedge clock);
    mc_resp_valid = 1'b0;
    n_tests++;
    if ({cpu_busy, cpu_done, cpu_error} !== 3'b000) begin
      n_fail++;
      $display("FAIL ack_after_reset: busy/done/err=%b want 000", {cpu_busy, cpu_done, cpu_error});
    end
    run_access("lw_after_reset", 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 0, 0, 32'hCAFE_F00D);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      int r;
      logic [1:0]  sz;
      logic [31:0] a;
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      run_access($sformatf("rand%0d", k), 1'($urandom), sz, 1'($urandom), a, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_random();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
